// File: rtl/obstacle_guard_pkg.sv
// -----------------------------------------------------------------------------
// obstacle_guard_pkg
// Shared definitions for the obstacle guard:
//   - FSM state encodings (2-bit, kept as plain logic constants)
//   - default timeout / hysteresis threshold constants
//   - data path widths for distance samples and the running sum
//   - hyst_update(): one step of a set-below / clear-at-or-above hysteresis
// -----------------------------------------------------------------------------
package obstacle_guard_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;  // after reset, no measurement seen yet
  localparam logic [1:0] ST_WARMUP = 2'd1;  // fewer than 4 samples in the window
  localparam logic [1:0] ST_RUN    = 2'd2;  // full window, thresholds active
  localparam logic [1:0] ST_FAULT  = 2'd3;  // trigger strobe stopped arriving

  // Default parameter values
  localparam int unsigned DEF_TIMEOUT_CYCLES = 2_700_000;  // 100 ms at 27 MHz
  localparam int unsigned DEF_STOP_ON        = 200;
  localparam int unsigned DEF_STOP_OFF       = 250;
  localparam int unsigned DEF_SLOW_ON        = 500;
  localparam int unsigned DEF_SLOW_OFF       = 600;

  // Data path sizing: four 32-bit samples need two extra bits of headroom
  localparam int DIST_W    = 32;
  localparam int AVG_DEPTH = 4;
  localparam int SUM_W     = DIST_W + 2;

  // Set when the value drops below on_th, clear when it reaches off_th,
  // otherwise keep the current level.
  function automatic logic hyst_update(
    input logic              cur,
    input logic [DIST_W-1:0] val,
    input logic [DIST_W-1:0] on_th,
    input logic [DIST_W-1:0] off_th
  );
    logic res;
    if (val < on_th) begin
      res = 1'b1;
    end else if (val >= off_th) begin
      res = 1'b0;
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/obstacle_guard_dist_avg4.sv
// -----------------------------------------------------------------------------
// dist_avg4
// Four-sample moving average of captured distances.
//   clk_i          system clock, rising edge
//   nreset_i       asynchronous active-low reset
//   clear_i        synchronous flush of window, sum, pointer and count
//                  (avg_o keeps its last value)
//   sample_valid_i store sample_i into the window this cycle
//   sample_i       distance sample, unsigned
//   count_o        number of samples held before this cycle's store (0..4)
//   avg_o          running sum / 4 (truncating), registered
//   avg_valid_o    one-cycle pulse when avg_o takes a full-window value
// The sum is updated at the capture edge; avg_o/avg_valid_o follow one
// cycle later.
// -----------------------------------------------------------------------------
module dist_avg4
  import obstacle_guard_pkg::*;
(
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic              clear_i,
  input  logic              sample_valid_i,
  input  logic [DIST_W-1:0] sample_i,
  output logic [2:0]        count_o,
  output logic [DIST_W-1:0] avg_o,
  output logic              avg_valid_o
);

  logic [DIST_W-1:0] buf_reg [AVG_DEPTH];
  logic [1:0]        wr_ptr_reg;
  logic [SUM_W-1:0]  sum_reg;
  logic [SUM_W-1:0]  sum_next;
  logic [2:0]        count_reg;
  logic              full_pend_reg;
  logic [DIST_W-1:0] avg_reg;
  logic              avg_valid_reg;
  logic [DIST_W-1:0] oldest;

  // The slot about to be overwritten; zero while the window is still
  // filling because the buffer starts cleared.
  assign oldest = buf_reg[wr_ptr_reg];

  // Intermediate sum + new may wrap past 34 bits, but the final result of
  // four 32-bit samples always fits, so modular arithmetic stays exact.
  assign sum_next = sum_reg + SUM_W'(sample_i) - SUM_W'(oldest);

  // Window storage, pointer, sum and fill count
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        buf_reg[i] <= '0;
      end
      wr_ptr_reg    <= '0;
      sum_reg       <= '0;
      count_reg     <= '0;
      full_pend_reg <= 1'b0;
    end else if (clear_i) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        buf_reg[i] <= '0;
      end
      wr_ptr_reg    <= '0;
      sum_reg       <= '0;
      count_reg     <= '0;
      full_pend_reg <= 1'b0;
    end else begin
      full_pend_reg <= 1'b0;
      if (sample_valid_i) begin
        buf_reg[wr_ptr_reg] <= sample_i;
        wr_ptr_reg          <= wr_ptr_reg + 2'd1;
        sum_reg             <= sum_next;
        if (count_reg != 3'd4) begin
          count_reg <= count_reg + 3'd1;
        end
        // This store completes (or keeps) a full window
        full_pend_reg <= (count_reg >= 3'd3);
      end
    end
  end

  // Output stage: publish the average one cycle after the capture
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      avg_reg       <= '0;
      avg_valid_reg <= 1'b0;
    end else if (clear_i) begin
      avg_valid_reg <= 1'b0;
    end else begin
      avg_valid_reg <= full_pend_reg;
      if (full_pend_reg) begin
        avg_reg <= sum_reg[SUM_W-1:2];
      end
    end
  end

  assign count_o     = count_reg;
  assign avg_o       = avg_reg;
  assign avg_valid_o = avg_valid_reg;

endmodule

// File: rtl/obstacle_guard.sv
// -----------------------------------------------------------------------------
// obstacle_guard
// Supervises an ultrasonic distance front end and derives motor limits.
//   clk_i        system clock, rising edge
//   nreset_i     asynchronous active-low reset
//   trig_i       trigger strobe from the front end; each rising edge marks
//                that dist_i holds the previous measurement
//   dist_i       distance result, unsigned
//   avg_o        4-sample moving average
//   avg_valid_o  one-cycle pulse on each full-window average update
//   stop_o       obstacle too close or sensor unusable
//   slow_o       obstacle near (also set whenever stop_o is set)
//   fault_o      trigger strobe timed out
// Holds the FSM, the trigger watchdog and the stop/slow hysteresis; the
// averaging window lives in dist_avg4.
// -----------------------------------------------------------------------------
module obstacle_guard
  import obstacle_guard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned STOP_ON        = DEF_STOP_ON,
  parameter int unsigned STOP_OFF       = DEF_STOP_OFF,
  parameter int unsigned SLOW_ON        = DEF_SLOW_ON,
  parameter int unsigned SLOW_OFF       = DEF_SLOW_OFF
) (
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic              trig_i,
  input  logic [DIST_W-1:0] dist_i,
  output logic [DIST_W-1:0] avg_o,
  output logic              avg_valid_o,
  output logic              stop_o,
  output logic              slow_o,
  output logic              fault_o
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [DIST_W-1:0] STOP_ON_T  = DIST_W'(STOP_ON);
  localparam logic [DIST_W-1:0] STOP_OFF_T = DIST_W'(STOP_OFF);
  localparam logic [DIST_W-1:0] SLOW_ON_T  = DIST_W'(SLOW_ON);
  localparam logic [DIST_W-1:0] SLOW_OFF_T = DIST_W'(SLOW_OFF);

  logic              trig_q_reg;
  logic              rise;
  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [WD_W-1:0]   wd_reg;
  logic [WD_W-1:0]   wd_next;
  logic              watch_active;
  logic              timeout;
  logic              sample_valid;
  logic              avg_clear;
  logic              stop_reg;
  logic              stop_next;
  logic              slow_reg;
  logic              slow_next;
  logic [2:0]        avg_count;
  logic [DIST_W-1:0] avg_val;
  logic              avg_valid;

  // Trigger edge detect
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      trig_q_reg <= 1'b0;
    end else begin
      trig_q_reg <= trig_i;
    end
  end

  assign rise = trig_i & ~trig_q_reg;

  // Watchdog only matters once measurements are flowing
  assign watch_active = (state_reg == ST_WARMUP) || (state_reg == ST_RUN);

  // The timeout fires on the edge where the counter would reach its limit,
  // so fault_o appears exactly TIMEOUT_CYCLES edges after the last rise.
  // A rise on that same edge takes priority.
  assign timeout = watch_active && !rise && (wd_reg >= WD_LAST);

  // FSM next state and window control
  always_comb begin
    state_next   = state_reg;
    sample_valid = 1'b0;
    avg_clear    = 1'b0;
    case (state_reg)
      ST_IDLE, ST_FAULT: begin
        // First edge only arms the pipeline: its dist_i belongs to a
        // measurement started before we were listening, so it is dropped.
        if (rise) begin
          state_next = ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (rise) begin
          sample_valid = 1'b1;
          if (avg_count == 3'd3) begin
            state_next = ST_RUN;
          end
        end else if (timeout) begin
          state_next = ST_FAULT;
          avg_clear  = 1'b1;
        end
      end
      ST_RUN: begin
        if (rise) begin
          sample_valid = 1'b1;
        end else if (timeout) begin
          state_next = ST_FAULT;
          avg_clear  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Watchdog counter: cleared by a rise, saturating otherwise
  always_comb begin
    wd_next = wd_reg;
    if (rise || (state_reg == ST_IDLE)) begin
      wd_next = '0;
    end else if (wd_reg != WD_LIMIT) begin
      wd_next = wd_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_reg <= ST_IDLE;
      wd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      wd_reg    <= wd_next;
    end
  end

  // Hysteresis on the averaged distance. Outside RUN both limits are
  // forced on, and the forcing is keyed on state_next so it takes effect
  // on the same edge as a fault.
  always_comb begin
    stop_next = stop_reg;
    slow_next = slow_reg;
    if (state_next != ST_RUN) begin
      stop_next = 1'b1;
      slow_next = 1'b1;
    end else if (avg_valid) begin
      stop_next = hyst_update(stop_reg, avg_val, STOP_ON_T, STOP_OFF_T);
      slow_next = hyst_update(slow_reg, avg_val, SLOW_ON_T, SLOW_OFF_T) | stop_next;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      stop_reg <= 1'b1;
      slow_reg <= 1'b1;
    end else begin
      stop_reg <= stop_next;
      slow_reg <= slow_next;
    end
  end

  dist_avg4 u_avg (
    .clk_i          (clk_i),
    .nreset_i       (nreset_i),
    .clear_i        (avg_clear),
    .sample_valid_i (sample_valid),
    .sample_i       (dist_i),
    .count_o        (avg_count),
    .avg_o          (avg_val),
    .avg_valid_o    (avg_valid)
  );

  assign avg_o       = avg_val;
  assign avg_valid_o = avg_valid;
  assign stop_o      = stop_reg;
  assign slow_o      = slow_reg;
  assign fault_o     = (state_reg == ST_FAULT);

endmodule
